// File: rtl/timer_ip_if.sv
// Memory-map bus bundle between the master and the timer peripheral.
// The slave returns rd combinationally in the same cycle as the request.
interface timer_ip_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] address;
  logic                  we;
  logic                  re;
  logic [DATA_WIDTH-1:0] rd;

  modport master (output wd, output address, output we, output re, input rd);
  modport slave  (input wd, input address, input we, input re, output rd);
endinterface

// File: rtl/timer_ip.sv
// Memory-mapped timer: prescaled up-counter with compare, periodic or one-shot
// operation, sticky match flag and level interrupt.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | en=0: prescaler held at 0, count frozen
// ST_RUN  | en=1: prescaler advancing, count steps on every tick
module timer_ip #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32,
  parameter int PRE_WIDTH  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  timer_ip_if.slave  bus,
  output logic       irq
);

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_CMP    = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                 state_q, state_d;
  logic                   one_shot_q, one_shot_d;
  logic                   irq_en_q, irq_en_d;
  logic [PRE_WIDTH-1:0]   prescale_q, prescale_d;
  logic [PRE_WIDTH-1:0]   pre_cnt_q, pre_cnt_d;
  logic [CNT_WIDTH-1:0]   cmp_q, cmp_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic                   match_q, match_d;

  logic [1:0]             reg_sel;
  logic                   ctrl_wr, cmp_wr, count_wr, status_wr;
  logic                   run, tick, hit;
  logic [PRE_WIDTH-1:0]   wr_prescale;
  logic [DATA_WIDTH-1:0]  rd_val;
  logic                   unused_bits;

  assign reg_sel     = bus.address[3:2];
  assign ctrl_wr     = bus.we && (reg_sel == REG_CTRL);
  assign cmp_wr      = bus.we && (reg_sel == REG_CMP);
  assign count_wr    = bus.we && (reg_sel == REG_COUNT);
  assign status_wr   = bus.we && (reg_sel == REG_STATUS);
  assign wr_prescale = bus.wd[8 +: PRE_WIDTH];

  assign run  = (state_q == ST_RUN);
  assign tick = run && (pre_cnt_q == prescale_q);
  // A COUNT write in the tick cycle suppresses match evaluation entirely.
  assign hit  = tick && (count_q == cmp_q) && !count_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      one_shot_q <= 1'b0;
      irq_en_q   <= 1'b0;
      prescale_q <= '0;
      pre_cnt_q  <= '0;
      cmp_q      <= '0;
      count_q    <= '0;
      match_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      one_shot_q <= one_shot_d;
      irq_en_q   <= irq_en_d;
      prescale_q <= prescale_d;
      pre_cnt_q  <= pre_cnt_d;
      cmp_q      <= cmp_d;
      count_q    <= count_d;
      match_q    <= match_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    one_shot_d = one_shot_q;
    irq_en_d   = irq_en_q;
    prescale_d = prescale_q;
    pre_cnt_d  = pre_cnt_q;
    cmp_d      = cmp_q;
    count_d    = count_q;
    match_d    = match_q;

    unique case (state_q)
      ST_IDLE: if (ctrl_wr && bus.wd[0]) state_d = ST_RUN;
      ST_RUN: begin
        // Software CTRL write outranks the one-shot auto-stop.
        if (ctrl_wr)                  state_d = bus.wd[0] ? ST_RUN : ST_IDLE;
        else if (hit && one_shot_q)   state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (!run || tick) pre_cnt_d = '0;
    else              pre_cnt_d = pre_cnt_q + PRE_WIDTH'(1);
    if (ctrl_wr && (!bus.wd[0] || (wr_prescale != prescale_q))) pre_cnt_d = '0;
    if (count_wr) pre_cnt_d = '0;

    if (count_wr)  count_d = bus.wd[CNT_WIDTH-1:0];
    else if (hit)  count_d = '0;
    else if (tick) count_d = count_q + CNT_WIDTH'(1);

    if (hit)                         match_d = 1'b1;
    else if (status_wr && bus.wd[0]) match_d = 1'b0;

    if (ctrl_wr) begin
      one_shot_d = bus.wd[1];
      irq_en_d   = bus.wd[2];
      prescale_d = wr_prescale;
    end
    if (cmp_wr) cmp_d = bus.wd[CNT_WIDTH-1:0];
  end

  always_comb begin
    rd_val = '0;
    unique case (reg_sel)
      REG_CTRL: begin
        rd_val[0]              = run;
        rd_val[1]              = one_shot_q;
        rd_val[2]              = irq_en_q;
        rd_val[8 +: PRE_WIDTH] = prescale_q;
      end
      REG_CMP:    rd_val = DATA_WIDTH'(cmp_q);
      REG_COUNT:  rd_val = DATA_WIDTH'(count_q);
      REG_STATUS: rd_val[0] = match_q;
      default:    rd_val = '0;
    endcase
  end

  assign bus.rd = bus.re ? rd_val : '0;
  assign irq    = match_q & irq_en_q;

  assign unused_bits = ^{bus.address[DATA_WIDTH-1:4], bus.address[1:0], bus.wd};

endmodule

// File: tb/tb_timer_ip.sv
// Bench for timer_ip: directed scenarios against fixed expected values, then
// randomized bus traffic against a cycle-level behavioural model.
module tb_timer_ip;
  localparam logic [31:0] A_CTRL = 32'h0, A_CMP = 32'h4, A_COUNT = 32'h8, A_STATUS = 32'hC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic irq;
  always #5 clk = ~clk;

  timer_ip_if #(.DATA_WIDTH(32)) bus();
  timer_ip #(.DATA_WIDTH(32), .CNT_WIDTH(32), .PRE_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .irq(irq)
  );

  int n_checks = 0;
  int n_pass = 0;

  // Behavioural model: programmer-visible registers plus the prescale phase.
  bit          m_en, m_os, m_ie, m_flag;
  int unsigned m_ps, m_pc;
  logic [31:0] m_cmp, m_cnt;

  function automatic void model_reset();
    m_en = 0; m_os = 0; m_ie = 0; m_flag = 0;
    m_ps = 0; m_pc = 0; m_cmp = 0; m_cnt = 0;
  endfunction

  function automatic void model_step(logic w, logic [31:0] a, logic [31:0] d);
    bit          ticking, matched, n_en, n_flag;
    int unsigned n_pc, idx;
    logic [31:0] n_cnt;
    ticking = m_en && (m_pc == m_ps);
    matched = ticking && (m_cnt == m_cmp);
    n_en = m_en; n_flag = m_flag; n_cnt = m_cnt;
    n_pc = (m_en && !ticking) ? m_pc + 1 : 0;
    if (matched) begin
      n_cnt = 0; n_flag = 1;
      if (m_os) n_en = 0;
    end else if (ticking) n_cnt = m_cnt + 1;
    idx = int'(a[3:2]);
    if (w) begin
      if (idx == 0) begin
        if (!d[0] || int'(d[15:8]) != m_ps) n_pc = 0;
        n_en = d[0]; m_os = d[1]; m_ie = d[2]; m_ps = int'(d[15:8]);
      end else if (idx == 1) m_cmp = d;
      else if (idx == 2) begin
        n_cnt = d; n_pc = 0; n_flag = m_flag; n_en = m_en;
      end else if (d[0] && !matched) n_flag = 0;
    end
    m_en = n_en; m_flag = n_flag; m_cnt = n_cnt; m_pc = n_pc;
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] a);
    case (a[3:2])
      2'd0:    return 32'(m_en) | (32'(m_os) << 1) | (32'(m_ie) << 2) | (m_ps << 8);
      2'd1:    return m_cmp;
      2'd2:    return m_cnt;
      default: return 32'(m_flag);
    endcase
  endfunction

  task automatic tick_cycle();
    model_step(bus.we, bus.address, bus.wd);
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.we = 1'b1; bus.address = a; bus.wd = d;
    tick_cycle();
    bus.we = 1'b0; bus.wd = '0;
  endtask

  task automatic rd_reg(input logic [31:0] a, output logic [31:0] v);
    bus.re = 1'b1; bus.address = a;
    #1;
    v = bus.rd;
    bus.re = 1'b0;
  endtask

  task automatic do_reset();
    bus.we = 1'b0; bus.re = 1'b0; bus.wd = '0; bus.address = '0;
    rst_n = 1'b0;
    model_reset();
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    do_reset();
    tick_cycle();
    wr(A_CMP, 32'd2);
    wr(A_CTRL, 32'h5);
    repeat (4) tick_cycle();
    n_checks++; if (irq !== 1'b1) $display("FAIL pre_reset_irq: got %b want 1", irq); else n_pass++;
    rst_n = 1'b0;
    model_reset();
    #2;
    n_checks++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else n_pass++;
    for (int r = 0; r < 4; r++) begin
      rd_reg(32'(r) << 2, v);
      n_checks++; if (v !== 32'd0) $display("FAIL reset_reg%0d: got %h want 0", r, v); else n_pass++;
    end
    rst_n = 1'b1;
    repeat (5) tick_cycle();
    rd_reg(A_COUNT, v);
    n_checks++; if (v !== 32'd0) $display("FAIL reset_frozen: got %h want 0", v); else n_pass++;
    rd_reg(A_CTRL, v);
    n_checks++; if (v !== 32'd0) $display("FAIL reset_ctrl_after: got %h want 0", v); else n_pass++;
  endtask

  task automatic test_periodic();
    logic [31:0] v;
    do_reset();
    wr(A_CMP, 32'd3);
    wr(A_CTRL, 32'h5);
    for (int i = 0; i < 10; i++) begin
      rd_reg(A_COUNT, v);
      n_checks++; if (v !== 32'(i % 4)) $display("FAIL periodic_count[%0d]: got %h want %h", i, v, i % 4); else n_pass++;
      rd_reg(A_STATUS, v);
      n_checks++; if (v !== 32'(i >= 4)) $display("FAIL periodic_flag[%0d]: got %h want %h", i, v, i >= 4); else n_pass++;
      n_checks++; if (irq !== (i >= 4)) $display("FAIL periodic_irq[%0d]: got %b want %b", i, irq, i >= 4); else n_pass++;
      tick_cycle();
    end
    wr(A_STATUS, 32'h1);
    rd_reg(A_STATUS, v);
    n_checks++; if (v !== 32'd0) $display("FAIL periodic_w1c: got %h want 0", v); else n_pass++;
    n_checks++; if (irq !== 1'b0) $display("FAIL periodic_irq_clr: got %b want 0", irq); else n_pass++;
  endtask

  task automatic test_prescale();
    logic [31:0] v;
    do_reset();
    wr(A_CMP, 32'd2);
    wr(A_CTRL, 32'h401);
    for (int i = 0; i < 17; i++) begin
      rd_reg(A_COUNT, v);
      n_checks++; if (v !== 32'((i / 5) % 3)) $display("FAIL prescale_count[%0d]: got %h want %h", i, v, (i / 5) % 3); else n_pass++;
      rd_reg(A_STATUS, v);
      n_checks++; if (v !== 32'(i >= 15)) $display("FAIL prescale_flag[%0d]: got %h want %h", i, v, i >= 15); else n_pass++;
      tick_cycle();
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    do_reset();
    wr(A_CMP, 32'd1);
    wr(A_CTRL, 32'h3);
    for (int i = 0; i < 7; i++) begin
      rd_reg(A_COUNT, v);
      n_checks++; if (v !== 32'(i == 1)) $display("FAIL oneshot_count[%0d]: got %h want %h", i, v, i == 1); else n_pass++;
      tick_cycle();
    end
    rd_reg(A_CTRL, v);
    n_checks++; if (v !== 32'h2) $display("FAIL oneshot_ctrl: got %h want 2", v); else n_pass++;
    rd_reg(A_STATUS, v);
    n_checks++; if (v !== 32'h1) $display("FAIL oneshot_flag: got %h want 1", v); else n_pass++;
    n_checks++; if (irq !== 1'b0) $display("FAIL oneshot_irq: got %b want 0", irq); else n_pass++;
  endtask

  task automatic test_collisions();
    logic [31:0] v;
    do_reset();
    wr(A_CMP, 32'd3);
    wr(A_CTRL, 32'h5);
    repeat (3) tick_cycle();
    wr(A_STATUS, 32'h1);
    rd_reg(A_STATUS, v);
    n_checks++; if (v !== 32'h1) $display("FAIL coll_w1c_vs_set: got %h want 1", v); else n_pass++;
    rd_reg(A_COUNT, v);
    n_checks++; if (v !== 32'h0) $display("FAIL coll_w1c_count: got %h want 0", v); else n_pass++;

    do_reset();
    wr(A_CMP, 32'd3);
    wr(A_CTRL, 32'h1);
    repeat (3) tick_cycle();
    wr(A_COUNT, 32'h10);
    rd_reg(A_COUNT, v);
    n_checks++; if (v !== 32'h10) $display("FAIL coll_count_wr: got %h want 10", v); else n_pass++;
    rd_reg(A_STATUS, v);
    n_checks++; if (v !== 32'h0) $display("FAIL coll_count_noflag: got %h want 0", v); else n_pass++;

    do_reset();
    wr(A_CMP, 32'd1);
    wr(A_CTRL, 32'h3);
    tick_cycle();
    wr(A_CTRL, 32'h3);
    rd_reg(A_CTRL, v);
    n_checks++; if (v !== 32'h3) $display("FAIL coll_ctrl_en: got %h want 3", v); else n_pass++;
    rd_reg(A_STATUS, v);
    n_checks++; if (v !== 32'h1) $display("FAIL coll_ctrl_flag: got %h want 1", v); else n_pass++;
    tick_cycle();
    rd_reg(A_COUNT, v);
    n_checks++; if (v !== 32'h1) $display("FAIL coll_ctrl_running: got %h want 1", v); else n_pass++;

    do_reset();
    wr(A_CMP, 32'd2);
    wr(A_CTRL, 32'h1);
    repeat (2) tick_cycle();
    wr(A_CMP, 32'd5);
    rd_reg(A_STATUS, v);
    n_checks++; if (v !== 32'h1) $display("FAIL coll_cmp_old_flag: got %h want 1", v); else n_pass++;
    rd_reg(A_COUNT, v);
    n_checks++; if (v !== 32'h0) $display("FAIL coll_cmp_old_count: got %h want 0", v); else n_pass++;

    do_reset();
    wr(A_CMP, 32'd100);
    wr(A_CTRL, 32'h201);
    tick_cycle();
    wr(A_CTRL, 32'h301);
    repeat (3) tick_cycle();
    rd_reg(A_COUNT, v);
    n_checks++; if (v !== 32'h0) $display("FAIL coll_pre_change_hold: got %h want 0", v); else n_pass++;
    tick_cycle();
    rd_reg(A_COUNT, v);
    n_checks++; if (v !== 32'h1) $display("FAIL coll_pre_change_step: got %h want 1", v); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0] v;
    do_reset();
    wr(A_COUNT, 32'hFFFF_FFFF);
    wr(A_CMP, 32'd5);
    wr(A_CTRL, 32'h1);
    rd_reg(A_COUNT, v);
    n_checks++; if (v !== 32'hFFFF_FFFF) $display("FAIL wrap_start: got %h want ffffffff", v); else n_pass++;
    tick_cycle();
    rd_reg(A_COUNT, v);
    n_checks++; if (v !== 32'h0) $display("FAIL wrap_zero: got %h want 0", v); else n_pass++;
    rd_reg(A_STATUS, v);
    n_checks++; if (v !== 32'h0) $display("FAIL wrap_noflag: got %h want 0", v); else n_pass++;
    repeat (5) tick_cycle();
    rd_reg(A_COUNT, v);
    n_checks++; if (v !== 32'h5) $display("FAIL wrap_at_cmp: got %h want 5", v); else n_pass++;
    tick_cycle();
    rd_reg(A_STATUS, v);
    n_checks++; if (v !== 32'h1) $display("FAIL wrap_flag: got %h want 1", v); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] v, a, d, exp;
    int unsigned idx;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        idx = $urandom_range(0, 3);
        case (idx)
          0: d = ($urandom & 32'hFFFF_00F8) | (32'($urandom_range(0, 3)) << 8)
                 | 32'($urandom_range(0, 6)) | 32'($urandom_range(0, 4) != 0);
          1: d = 32'($urandom_range(0, 6));
          2: d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 6));
          default: d = $urandom;
        endcase
        bus.we = 1'b1;
        bus.wd = d;
        bus.address = ($urandom & 32'hFFFF_FFF3) | (idx << 2);
      end
      a = ($urandom & 32'hFFFF_FFF3) | (32'($urandom_range(0, 3)) << 2);
      exp = model_read(a);
      bus.re = 1'b1;
      if (!bus.we) bus.address = a;
      else a = bus.address;
      exp = model_read(a);
      #1;
      v = bus.rd;
      bus.re = 1'b0;
      n_checks++; if (v !== exp) $display("FAIL rand_rd[%0d] addr %h: got %h want %h", i, a, v, exp); else n_pass++;
      n_checks++; if (irq !== (m_flag & m_ie)) $display("FAIL rand_irq[%0d]: got %b want %b", i, irq, m_flag & m_ie); else n_pass++;
      tick_cycle();
      bus.we = 1'b0;
      bus.wd = '0;
    end
    bus.re = 1'b0;
    rd_reg(A_CMP, v);
    n_checks++; if (v !== 32'd0 && v !== m_cmp) $display("FAIL rand_final_cmp: got %h want %h", v, m_cmp); else n_pass++;
  endtask

  initial begin
    bus.we = 1'b0; bus.re = 1'b0; bus.wd = '0; bus.address = '0;
    model_reset();
    #12;
    test_reset();
    test_periodic();
    test_prescale();
    test_oneshot();
    test_collisions();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
